// File: rtl/fmm_row_weight_scan.sv
// Rescans one row of M_e: nonzero count, max |element|, first nonzero index, all-zero flag.
// Optional early exit on the first nonzero word when FMM_SCAN_EARLY_EXIT_EN is defined.
module fmm_row_weight_scan #(
    parameter int ADDR_W = 17,
    parameter int DATA_W = 32
) (
    input  logic              ap_clk,
    input  logic              ap_rst,
    input  logic              ap_start,
    output logic              ap_done,
    output logic              ap_idle,
    output logic              ap_ready,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [31:0]       len,
    input  logic              zero_check_only,
    output logic [ADDR_W-1:0] M_e_address0,
    output logic              M_e_ce0,
    input  logic [DATA_W-1:0] M_e_q0,
    output logic [31:0]       nnz_count,
    output logic [DATA_W-1:0] max_abs,
    output logic [31:0]       first_nz_idx,
    output logic              is_zero
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    localparam logic [DATA_W-1:0] MIN_NEG = {1'b1, {(DATA_W-1){1'b0}}};
    localparam logic [DATA_W-1:0] MAX_POS = ~MIN_NEG;

    state_t            state_q;
    logic [ADDR_W-1:0] base_q;
    logic [31:0]       len_q;
    logic              zco_q;
    logic [31:0]       c_q;
    logic              rd_vld_q;
    logic [31:0]       rd_idx_q;
    logic [31:0]       nnz_q;
    logic [DATA_W-1:0] max_q;
    logic [31:0]       first_q;
    logic              is_zero_q;
    logic              done_q;
    logic              idle_q;
    logic              ce_q;
    logic [ADDR_W-1:0] addr_q;

    logic [DATA_W-1:0] q_abs;
    logic              acc_en;
    logic              hit;
    logic [31:0]       nnz_d;
    logic [DATA_W-1:0] max_d;
    logic [31:0]       first_d;
    logic [31:0]       c_d;
    logic              early_exit;

    // Data returned while in DONE belongs to a read issued after an early exit and is dropped.
    always_comb begin
        q_abs   = (M_e_q0 == MIN_NEG) ? MAX_POS : (M_e_q0[DATA_W-1] ? -M_e_q0 : M_e_q0);
        acc_en  = rd_vld_q && (state_q == S_RUN || state_q == S_DRAIN);
        hit     = acc_en && (M_e_q0 != '0);
        nnz_d   = hit ? nnz_q + 32'd1 : nnz_q;
        max_d   = (acc_en && q_abs > max_q) ? q_abs : max_q;
        first_d = (hit && nnz_q == 32'd0) ? rd_idx_q : first_q;
        c_d     = c_q + 32'd1;
    end

`ifdef FMM_SCAN_EARLY_EXIT_EN
    assign early_exit = zco_q && hit && (nnz_q == 32'd0);
`else
    logic unused_zco_q;
    assign unused_zco_q = zco_q;
    assign early_exit   = 1'b0;
`endif

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            state_q   <= S_IDLE;
            base_q    <= '0;
            len_q     <= '0;
            zco_q     <= 1'b0;
            c_q       <= '0;
            rd_vld_q  <= 1'b0;
            rd_idx_q  <= '0;
            nnz_q     <= '0;
            max_q     <= '0;
            first_q   <= '1;
            is_zero_q <= 1'b0;
            done_q    <= 1'b0;
            idle_q    <= 1'b1;
            ce_q      <= 1'b0;
            addr_q    <= '0;
        end else begin
            done_q   <= 1'b0;
            rd_vld_q <= ce_q;
            rd_idx_q <= c_q;
            nnz_q    <= nnz_d;
            max_q    <= max_d;
            first_q  <= first_d;
            case (state_q)
                S_IDLE: begin
                    if (ap_start) begin
                        base_q    <= base_addr;
                        len_q     <= len;
                        zco_q     <= zero_check_only;
                        c_q       <= '0;
                        nnz_q     <= '0;
                        max_q     <= '0;
                        first_q   <= '1;
                        is_zero_q <= 1'b0;
                        idle_q    <= 1'b0;
                        if (len[31] || len == 32'd0) begin
                            state_q   <= S_DONE;
                            done_q    <= 1'b1;
                            is_zero_q <= 1'b1;
                        end else begin
                            state_q <= S_RUN;
                            ce_q    <= 1'b1;
                            addr_q  <= base_addr;
                        end
                    end
                end
                S_RUN: begin
                    if (early_exit) begin
                        ce_q      <= 1'b0;
                        state_q   <= S_DONE;
                        done_q    <= 1'b1;
                        is_zero_q <= (nnz_d == 32'd0);
                    end else if (c_q == len_q - 32'd1) begin
                        ce_q    <= 1'b0;
                        state_q <= S_DRAIN;
                    end else begin
                        c_q    <= c_d;
                        addr_q <= base_q + c_d[ADDR_W-1:0];
                    end
                end
                S_DRAIN: begin
                    state_q   <= S_DONE;
                    done_q    <= 1'b1;
                    is_zero_q <= (nnz_d == 32'd0);
                end
                default: begin
                    state_q <= S_IDLE;
                    idle_q  <= 1'b1;
                end
            endcase
        end
    end

    assign ap_done      = done_q;
    assign ap_ready     = done_q;
    assign ap_idle      = idle_q;
    assign M_e_ce0      = ce_q;
    assign M_e_address0 = addr_q;
    assign nnz_count    = nnz_q;
    assign max_abs      = max_q;
    assign first_nz_idx = first_q;
    assign is_zero      = is_zero_q;

endmodule

// File: tb/tb_fmm_row_weight_scan.sv
// Bench for fmm_row_weight_scan: vector table, hand sequences, random scans against a row model.
module tb_fmm_row_weight_scan;

    logic        ap_clk;
    logic        ap_rst;
    logic        ap_start;
    logic        ap_done;
    logic        ap_idle;
    logic        ap_ready;
    logic [16:0] base_addr;
    logic [31:0] len;
    logic        zero_check_only;
    logic [16:0] M_e_address0;
    logic        M_e_ce0;
    logic [31:0] M_e_q0;
    logic [31:0] nnz_count;
    logic [31:0] max_abs;
    logic [31:0] first_nz_idx;
    logic        is_zero;

    int checks = 0;
    int failures = 0;

    logic [31:0] mem [0:131071];

    fmm_row_weight_scan #(.ADDR_W(17), .DATA_W(32)) dut (
        .ap_clk(ap_clk), .ap_rst(ap_rst), .ap_start(ap_start),
        .ap_done(ap_done), .ap_idle(ap_idle), .ap_ready(ap_ready),
        .base_addr(base_addr), .len(len), .zero_check_only(zero_check_only),
        .M_e_address0(M_e_address0), .M_e_ce0(M_e_ce0), .M_e_q0(M_e_q0),
        .nnz_count(nnz_count), .max_abs(max_abs), .first_nz_idx(first_nz_idx),
        .is_zero(is_zero)
    );

    initial begin
        ap_clk = 1'b0;
        forever #5 ap_clk = ~ap_clk;
    end

    always @(posedge ap_clk) if (M_e_ce0) M_e_q0 <= mem[M_e_address0];

    typedef struct {
        logic [16:0] base;
        int          len;
        logic        zco;
        logic [31:0] d [6];
        int          e_nnz;
        logic [31:0] e_max;
        logic [31:0] e_first;
        logic        e_zero;
        int          e_lat;
        int          e_iss;
    } vec_t;

    task automatic chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Row semantics straight from the rules: walk the elements, stop early if allowed.
    task automatic model(input logic [16:0] b, input int l, input logic z,
                         output int nnz, output logic [31:0] mx, output logic [31:0] first,
                         output logic zero, output int lat, output int iss);
        bit     ee = 1'b0;
        int     stop_i = -1;
        longint sv, aa;
`ifdef FMM_SCAN_EARLY_EXIT_EN
        ee = 1'b1;
`endif
        nnz = 0; mx = 0; first = 32'hFFFFFFFF;
        for (int i = 0; i < l && stop_i < 0; i++) begin
            sv = longint'($signed(mem[17'(b + 17'(i))]));
            aa = (sv < 0) ? -sv : sv;
            if (aa > 64'h7FFFFFFF) aa = 64'h7FFFFFFF;
            if (aa > longint'(mx)) mx = 32'(aa);
            if (sv != 0) begin
                nnz++;
                if (nnz == 1) first = 32'(i);
                if (ee && z) stop_i = i;
            end
        end
        zero = (nnz == 0);
        if (l <= 0) begin lat = 1; iss = 0; end
        else if (stop_i >= 0) begin
            lat = stop_i + 3;
            iss = (stop_i + 2 < l) ? stop_i + 2 : l;
        end else begin lat = l + 2; iss = l; end
    endtask

    task automatic do_scan(input logic [16:0] b, input int l, input logic z,
                           output int r_nnz, output logic [31:0] r_max, output logic [31:0] r_first,
                           output logic r_zero, output int r_lat, output int r_iss,
                           output int r_abad, output logic r_rdy, output logic r_after);
        logic [16:0] addrs[$];
        bit got = 0;
        int cyc = 0;
        @(negedge ap_clk);
        base_addr = b; len = 32'(l); zero_check_only = z; ap_start = 1'b1;
        r_nnz = -1; r_max = 'x; r_first = 'x; r_zero = 1'bx; r_rdy = 1'b0; r_lat = -1;
        while (!got && cyc < 200) begin
            @(negedge ap_clk);
            ap_start = 1'b0;
            cyc++;
            if (M_e_ce0) addrs.push_back(M_e_address0);
            if (ap_done) begin
                got = 1; r_lat = cyc; r_rdy = ap_ready;
                r_nnz = int'(nnz_count); r_max = max_abs; r_first = first_nz_idx; r_zero = is_zero;
            end
        end
        if (!got) $display("FAIL timeout: no ap_done within %0d cycles", cyc);
        r_iss = addrs.size();
        r_abad = 0;
        foreach (addrs[j]) if (addrs[j] != 17'(b + 17'(j))) r_abad++;
        @(negedge ap_clk);
        r_after = !ap_done && !ap_ready && ap_idle && (int'(nnz_count) == r_nnz);
    endtask

    function automatic vec_t mk(logic [16:0] b, int l, logic z,
                                logic [31:0] d0, logic [31:0] d1, logic [31:0] d2,
                                logic [31:0] d3, logic [31:0] d4, logic [31:0] d5,
                                int en, logic [31:0] em, logic [31:0] ef, logic ez, int el, int ei);
        vec_t v;
        v.base = b; v.len = l; v.zco = z;
        v.d[0] = d0; v.d[1] = d1; v.d[2] = d2; v.d[3] = d3; v.d[4] = d4; v.d[5] = d5;
        v.e_nnz = en; v.e_max = em; v.e_first = ef; v.e_zero = ez; v.e_lat = el; v.e_iss = ei;
        return v;
    endfunction

    initial begin
        vec_t        tv[8];
        int          r_nnz, r_lat, r_iss, r_abad;
        logic [31:0] r_max, r_first;
        logic        r_zero, r_rdy, r_after;
        int          e_nnz, e_lat, e_iss;
        logic [31:0] e_max, e_first;
        logic        e_zero;

        tv[0] = mk(17'd5, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 32'hFFFFFFFF, 1, 1, 0);
        tv[1] = mk(17'd100, 4, 0, 32'h0, 32'h5, 32'hFFFFFFF9, 32'h0, 0, 0,
                   2, 32'h7, 32'h1, 0, 6, 4);
        tv[2] = mk(17'h1FFFE, 4, 0, 32'h0, 32'hFFFFFFFD, 32'h80000000, 32'h4, 0, 0,
                   3, 32'h7FFFFFFF, 32'h1, 0, 6, 4);
        tv[3] = mk(17'd300, -5, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 32'hFFFFFFFF, 1, 1, 0);
        tv[4] = mk(17'd400, 1, 0, 32'hFFFFFFFF, 0, 0, 0, 0, 0, 1, 32'h1, 32'h0, 0, 3, 1);
`ifdef FMM_SCAN_EARLY_EXIT_EN
        tv[5] = mk(17'd500, 6, 1, 0, 0, 32'd9, 0, 0, 32'd3, 1, 32'h9, 32'h2, 0, 5, 4);
`else
        tv[5] = mk(17'd500, 6, 1, 0, 0, 32'd9, 0, 0, 32'd3, 2, 32'h9, 32'h2, 0, 8, 6);
`endif
        tv[6] = mk(17'd600, 6, 1, 0, 0, 0, 0, 0, 0, 0, 32'h0, 32'hFFFFFFFF, 1, 8, 6);
        tv[7] = mk(17'd700, 5, 0, 0, 0, 0, 0, 32'hFFFFFFFE, 0, 1, 32'h2, 32'h4, 0, 7, 5);

        ap_rst = 1'b1; ap_start = 1'b0; base_addr = '0; len = '0; zero_check_only = 1'b0;
        repeat (3) @(negedge ap_clk);
        chk("reset idle", ap_idle, 1);
        chk("reset done/ready/ce0", {ap_done, ap_ready, M_e_ce0}, 0);
        chk("reset addr", M_e_address0, 0);
        chk("reset nnz/max", {nnz_count, max_abs}, 0);
        chk("reset first", first_nz_idx, 32'hFFFFFFFF);
        chk("reset is_zero", is_zero, 0);
        ap_rst = 1'b0;

        for (int i = 0; i < 8; i++) begin
            for (int j = 0; j < tv[i].len; j++) mem[17'(tv[i].base + 17'(j))] = tv[i].d[j];
            do_scan(tv[i].base, tv[i].len, tv[i].zco,
                    r_nnz, r_max, r_first, r_zero, r_lat, r_iss, r_abad, r_rdy, r_after);
            chk($sformatf("tv%0d latency", i), r_lat, tv[i].e_lat);
            chk($sformatf("tv%0d nnz", i), r_nnz, tv[i].e_nnz);
            chk($sformatf("tv%0d max_abs", i), r_max, tv[i].e_max);
            chk($sformatf("tv%0d first", i), r_first, tv[i].e_first);
            chk($sformatf("tv%0d is_zero", i), r_zero, tv[i].e_zero);
            chk($sformatf("tv%0d issues", i), r_iss, tv[i].e_iss);
            chk($sformatf("tv%0d addr seq bad", i), r_abad, 0);
            chk($sformatf("tv%0d ready", i), r_rdy, 1);
            chk($sformatf("tv%0d pulse/hold", i), r_after, 1);
        end

        // ap_start held high: two back-to-back all-zero scans with one IDLE cycle between
        begin
            int d1 = -1, d2 = -1, n = 0;
            logic z1 = 0, z2 = 0, idle_gap = 0;
            for (int j = 0; j < 3; j++) mem[50 + j] = 32'h0;
            @(negedge ap_clk);
            base_addr = 17'd50; len = 32'd3; zero_check_only = 1'b0; ap_start = 1'b1;
            for (int cyc = 1; cyc <= 40 && n < 2; cyc++) begin
                @(negedge ap_clk);
                if (cyc == d1 + 1) idle_gap = ap_idle && !ap_done;
                if (ap_done) begin
                    if (n == 0) begin d1 = cyc; z1 = is_zero; end
                    else begin d2 = cyc; z2 = is_zero; ap_start = 1'b0; end
                    n++;
                end
            end
            ap_start = 1'b0;
            chk("b2b first done", d1, 5);
            chk("b2b second done", d2, 11);
            chk("b2b is_zero 1", z1, 1);
            chk("b2b is_zero 2", z2, 1);
            chk("b2b idle gap", idle_gap, 1);
            repeat (2) @(negedge ap_clk);
            chk("b2b stopped", {ap_idle, M_e_ce0, ap_done}, 3'b100);
        end

        // Reset asserted mid-scan, then a fresh scan
        begin
            for (int j = 0; j < 10; j++) mem[200 + j] = 32'(j + 1);
            @(negedge ap_clk);
            base_addr = 17'd200; len = 32'd10; zero_check_only = 1'b0; ap_start = 1'b1;
            for (int cyc = 1; cyc <= 5; cyc++) begin
                @(negedge ap_clk);
                ap_start = 1'b0;
            end
            chk("mid-scan ce0/addr", {M_e_ce0, M_e_address0}, {1'b1, 17'd204});
            ap_rst = 1'b1;
            @(negedge ap_clk);
            chk("rst idle/ce0/done", {ap_idle, M_e_ce0, ap_done}, 3'b100);
            chk("rst addr", M_e_address0, 0);
            chk("rst nnz/max", {nnz_count, max_abs}, 0);
            chk("rst first/is_zero", {first_nz_idx, is_zero}, {32'hFFFFFFFF, 1'b0});
            ap_rst = 1'b0;
            model(17'd200, 10, 0, e_nnz, e_max, e_first, e_zero, e_lat, e_iss);
            do_scan(17'd200, 10, 0, r_nnz, r_max, r_first, r_zero, r_lat, r_iss, r_abad, r_rdy, r_after);
            chk("post-rst latency", r_lat, e_lat);
            chk("post-rst nnz", r_nnz, e_nnz);
            chk("post-rst max", r_max, e_max);
        end

        for (int it = 0; it < 60; it++) begin
            logic [16:0] b;
            int l;
            logic z;
            b = (it % 4 == 0) ? 17'(17'h1FFF0 + 17'($urandom_range(0, 15)))
                              : 17'($urandom_range(0, 131071));
            l = int'($urandom_range(0, 18)) - 2;
            z = 1'($urandom_range(0, 1));
            for (int j = 0; j < l; j++) begin
                int sel = int'($urandom_range(0, 7));
                mem[17'(b + 17'(j))] = (sel < 4) ? 32'h0 :
                                       (sel == 4) ? 32'h80000000 :
                                       (sel == 5) ? -32'($urandom_range(1, 1000)) : $urandom;
            end
            model(b, l, z, e_nnz, e_max, e_first, e_zero, e_lat, e_iss);
            do_scan(b, l, z, r_nnz, r_max, r_first, r_zero, r_lat, r_iss, r_abad, r_rdy, r_after);
            chk($sformatf("rnd%0d latency", it), r_lat, e_lat);
            chk($sformatf("rnd%0d nnz", it), r_nnz, e_nnz);
            chk($sformatf("rnd%0d max_abs", it), r_max, e_max);
            chk($sformatf("rnd%0d first", it), r_first, e_first);
            chk($sformatf("rnd%0d is_zero", it), r_zero, e_zero);
            chk($sformatf("rnd%0d issues", it), r_iss, e_iss);
            chk($sformatf("rnd%0d addr seq bad", it), r_abad, 0);
            chk($sformatf("rnd%0d pulse/hold", it), r_after, 1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
